conv_pool: RTL and testbench

- Downstream stage of the convolution engine; consumes its row-major output stream of Rout x Cout signed results.
- Applies 2x2 stride-2 max-pooling, optional ReLU, and saturation to a narrower output width.
- Emits pooled results as a row-major AXI-Stream, one beat per 2x2 window.
- Needs one half-width line buffer and a single registered output stage.

---
 rtl/conv_pool_pkg.sv | 45 ++++
 rtl/pool_linebuf.sv | 23 ++
 rtl/conv_pool.sv | 153 +++++++++++++++
 tb/tb_conv_pool.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pool_pkg.sv
// Shared types, widths and arithmetic helpers for the 2x2 max-pool stage.
package conv_pool_pkg;

    localparam int POOL_IW   = 54;
    localparam int POOL_OW   = 24;
    localparam int POOL_MAXR = 16;
    localparam int POOL_MAXC = 17;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } pool_state_t;

    // Saturation bounds expressed at the full input width so the clamp compare is exact.
    localparam logic signed [POOL_IW-1:0] SAT_MAX = {{(POOL_IW-POOL_OW+1){1'b0}}, {(POOL_OW-1){1'b1}}};
    localparam logic signed [POOL_IW-1:0] SAT_MIN = {{(POOL_IW-POOL_OW+1){1'b1}}, {(POOL_OW-1){1'b0}}};

    function automatic logic signed [POOL_IW-1:0] max2(
        input logic signed [POOL_IW-1:0] a,
        input logic signed [POOL_IW-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    function automatic logic signed [POOL_IW-1:0] max3(
        input logic signed [POOL_IW-1:0] a,
        input logic signed [POOL_IW-1:0] b,
        input logic signed [POOL_IW-1:0] c
    );
        return max2(max2(a, b), c);
    endfunction

    function automatic logic [POOL_OW-1:0] sat_relu(
        input logic signed [POOL_IW-1:0] v,
        input logic                      relu
    );
        logic signed [POOL_IW-1:0] t;
        t = v;
        if (relu && t[POOL_IW-1]) t = '0;
        if (t > SAT_MAX) return SAT_MAX[POOL_OW-1:0];
        if (t < SAT_MIN) return SAT_MIN[POOL_OW-1:0];
        return t[POOL_OW-1:0];
    endfunction

endpackage

// File: rtl/pool_linebuf.sv
// Half-width line buffer holding the per-pair maxima of the even row; no reset on contents.
module pool_linebuf #(
    parameter int DEPTH = 8,
    parameter int W     = 54,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/conv_pool.sv
// 2x2 stride-2 max-pool with optional ReLU and saturation over a row-major AXI-Stream frame.
module conv_pool
    import conv_pool_pkg::*;
#(
    parameter int IW   = POOL_IW,
    parameter int OW   = POOL_OW,
    parameter int MAXR = POOL_MAXR,
    parameter int MAXC = POOL_MAXC
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [$clog2(MAXR):0]     cfg_rows,
    input  logic [$clog2(MAXC):0]     cfg_cols,
    input  logic                      cfg_relu,
    input  logic [IW-1:0]             IN_AXIS_TDATA,
    input  logic                      IN_AXIS_TVALID,
    output logic                      IN_AXIS_TREADY,
    output logic [OW-1:0]             OUT_AXIS_TDATA,
    output logic                      OUT_AXIS_TVALID,
    input  logic                      OUT_AXIS_TREADY,
    output logic                      frame_done,
    output pool_state_t               dbg_state
);

    localparam int RW  = $clog2(MAXR) + 1;
    localparam int CW  = $clog2(MAXC) + 1;
    localparam int LBD = MAXC / 2;
    localparam int LAW = $clog2(LBD);

    pool_state_t          state_q, state_d;
    logic [RW-1:0]        row_q, row_d, rows_q, rows_d, rows_eff;
    logic [CW-1:0]        col_q, col_d, cols_q, cols_d, cols_eff;
    logic                 relu_q, relu_d, relu_eff;
    logic signed [IW-1:0] h_q, h_d, x, lb_rdata, pair_max, win_max;
    logic [OW-1:0]        out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic                 done_q, done_d;
    logic                 accept, last_row, last_col, win_act, lb_we;
    logic [LAW-1:0]       lb_idx;

    // Valid/ready: a beat moves when VALID & READY at a clock edge; a producer holds
    // VALID and DATA stable until that edge. Input stalls only while the output register
    // is full and not draining, so every accepted beat has room for its result.
    assign IN_AXIS_TREADY  = !out_valid_q || OUT_AXIS_TREADY;
    assign accept          = IN_AXIS_TVALID && IN_AXIS_TREADY;
    assign x               = IN_AXIS_TDATA;
    assign lb_idx          = col_q[LAW:1];
    assign OUT_AXIS_TDATA  = out_data_q;
    assign OUT_AXIS_TVALID = out_valid_q;
    assign frame_done      = done_q;
    assign dbg_state       = state_q;

    pool_linebuf #(
        .DEPTH (LBD),
        .W     (IW),
        .AW    (LAW)
    ) u_linebuf (
        .clk     (clk),
        .we_i    (lb_we),
        .waddr_i (lb_idx),
        .wdata_i (pair_max),
        .raddr_i (lb_idx),
        .rdata_o (lb_rdata)
    );

    always_comb begin
        // In IDLE the first beat uses the live cfg inputs; they are latched on acceptance.
        rows_eff    = (state_q == IDLE) ? cfg_rows : rows_q;
        cols_eff    = (state_q == IDLE) ? cfg_cols : cols_q;
        relu_eff    = (state_q == IDLE) ? cfg_relu : relu_q;
        last_row    = (row_q == rows_eff - RW'(1));
        last_col    = (col_q == cols_eff - CW'(1));
        win_act     = (row_q < {rows_eff[RW-1:1], 1'b0}) && (col_q < {cols_eff[CW-1:1], 1'b0});
        pair_max    = max2(h_q, x);
        win_max     = max3(h_q, x, lb_rdata);

        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        rows_d      = rows_q;
        cols_d      = cols_q;
        relu_d      = relu_q;
        h_d         = h_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;
        lb_we       = 1'b0;

        if (out_valid_q && OUT_AXIS_TREADY) out_valid_d = 1'b0;

        if (accept) begin
            if (state_q == IDLE) begin
                rows_d = cfg_rows;
                cols_d = cfg_cols;
                relu_d = cfg_relu;
            end
            if (last_row && last_col) begin
                row_d   = '0;
                col_d   = '0;
                state_d = IDLE;
                done_d  = 1'b1;
            end else begin
                state_d = RUN;
                if (last_col) begin
                    col_d = '0;
                    row_d = row_q + RW'(1);
                end else begin
                    col_d = col_q + CW'(1);
                end
            end
            // Trailing odd row/column beats fall outside the window and are dropped.
            if (win_act) begin
                if (!col_q[0]) begin
                    h_d = x;
                end else if (!row_q[0]) begin
                    lb_we = 1'b1;
                end else begin
                    out_valid_d = 1'b1;
                    out_data_d  = sat_relu(win_max, relu_eff);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            row_q       <= '0;
            col_q       <= '0;
            rows_q      <= '0;
            cols_q      <= '0;
            relu_q      <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            rows_q      <= rows_d;
            cols_q      <= cols_d;
            relu_q      <= relu_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        h_q <= h_d;
    end

endmodule

// File: tb/tb_conv_pool.sv
// Directed bench for conv_pool: model-built expectations in a queue, checked as outputs drain.
module tb_conv_pool;
    import conv_pool_pkg::*;

    localparam int IW = POOL_IW;
    localparam int OW = POOL_OW;

    logic          clk;
    logic          reset;
    logic [4:0]    cfg_rows;
    logic [5:0]    cfg_cols;
    logic          cfg_relu;
    logic [IW-1:0] in_tdata;
    logic          in_tvalid;
    logic          in_tready;
    logic [OW-1:0] out_tdata;
    logic          out_tvalid;
    logic          out_tready;
    logic          frame_done;
    pool_state_t   dbg_state;

    conv_pool dut (
        .clk             (clk),
        .reset           (reset),
        .cfg_rows        (cfg_rows),
        .cfg_cols        (cfg_cols),
        .cfg_relu        (cfg_relu),
        .IN_AXIS_TDATA   (in_tdata),
        .IN_AXIS_TVALID  (in_tvalid),
        .IN_AXIS_TREADY  (in_tready),
        .OUT_AXIS_TDATA  (out_tdata),
        .OUT_AXIS_TVALID (out_tvalid),
        .OUT_AXIS_TREADY (out_tready),
        .frame_done      (frame_done),
        .dbg_state       (dbg_state)
    );

    // Clock and ready generation
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int  checks = 0;
    int  errors = 0;
    int  done_cnt = 0;
    int  cyc = 0;
    bit  bp = 0;
    bit  force_stall = 0;
    logic [OW-1:0] exp_q[$];
    longint frame_d[$];

    always @(posedge clk) begin
        #1;
        cyc++;
        if (force_stall)  out_tready = 1'b0;
        else if (bp)      out_tready = (cyc % 3 == 0);
        else              out_tready = 1'b1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard / monitor, sampled on the falling edge
    logic          prev_hold = 1'b0;
    logic [OW-1:0] prev_data = '0;

    always @(negedge clk) begin
        if (reset) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", 64'(out_tvalid), 64'(1'b1));
                check("hold_data", 64'(out_tdata), 64'(prev_data));
            end
            check("in_ready", 64'(in_tready), 64'(!(out_tvalid && !out_tready)));
            if (out_tvalid && out_tready) begin
                check("q_nonempty", 64'(exp_q.size() != 0), 64'(1'b1));
                if (exp_q.size() != 0) check("out_data", 64'(out_tdata), 64'(exp_q.pop_front()));
            end
            if (frame_done) done_cnt++;
            prev_hold = out_tvalid && !out_tready;
            prev_data = out_tdata;
        end
    end

    // Driver tasks
    task automatic send(input longint d, input bit is_last);
        bit acc = 0;
        int n = 0;
        in_tvalid = 1'b1;
        in_tdata  = d[IW-1:0];
        while (!acc) begin
            @(negedge clk);
            acc = in_tready;
            @(posedge clk);
            #1;
            n++;
            if (!acc && n > 200) begin
                check("in_accept_timeout", 64'(acc), 64'(1'b1));
                break;
            end
        end
        in_tvalid = 1'b0;
        if (acc) begin
            check("frame_done", 64'(frame_done), 64'(is_last));
            if (is_last) check("state_idle", 64'(dbg_state), 64'(IDLE));
        end
    endtask

    task automatic run_frame(input int rows, input int cols, input bit relu);
        longint m;
        longint v;
        for (int wr = 0; wr < rows / 2; wr++) begin
            for (int wc = 0; wc < cols / 2; wc++) begin
                m = frame_d[(2 * wr) * cols + 2 * wc];
                for (int k = 1; k < 4; k++) begin
                    v = frame_d[(2 * wr + k / 2) * cols + 2 * wc + k % 2];
                    if (v > m) m = v;
                end
                if (relu && m < 0) m = 0;
                if (m > 64'sd8388607) m = 64'sd8388607;
                if (m < -64'sd8388608) m = -64'sd8388608;
                exp_q.push_back(m[OW-1:0]);
            end
        end
        cfg_rows = 5'(rows);
        cfg_cols = 6'(cols);
        cfg_relu = relu;
        for (int i = 0; i < rows * cols; i++) begin
            send(frame_d[i], i == rows * cols - 1);
            if (i == 0) begin
                cfg_rows = 5'($urandom_range(1, 16));
                cfg_cols = 6'($urandom_range(1, 17));
                cfg_relu = 1'($urandom_range(0, 1));
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_empty", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        reset      = 1'b1;
        cfg_rows   = '0;
        cfg_cols   = '0;
        cfg_relu   = 1'b0;
        in_tdata   = '0;
        in_tvalid  = 1'b0;
        out_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 64'(out_tvalid), 64'(1'b0));
        check("rst_data", 64'(out_tdata), 64'(0));
        check("rst_done", 64'(frame_done), 64'(1'b0));
        check("rst_state", 64'(dbg_state), 64'(IDLE));
        reset = 1'b0;

        // 4x4 ramp -> 5,7,13,15
        frame_d.delete();
        for (int i = 0; i < 16; i++) frame_d.push_back(longint'(i));
        run_frame(4, 4, 1'b0);

        // 4x4 negative with and without ReLU
        frame_d.delete();
        for (int i = 0; i < 16; i++) frame_d.push_back(-longint'(i + 1));
        run_frame(4, 4, 1'b1);
        run_frame(4, 4, 1'b0);

        // 5x5 ramp, trailing row/column dropped -> 6,8,16,18
        frame_d.delete();
        for (int i = 0; i < 25; i++) frame_d.push_back(longint'(i));
        run_frame(5, 5, 1'b0);

        // Single-row frame: consumed, no output, still completes
        frame_d.delete();
        for (int i = 0; i < 3; i++) frame_d.push_back(longint'(7 + i));
        run_frame(1, 3, 1'b0);

        // Saturation at both rails
        frame_d.delete();
        frame_d.push_back(longint'(1) << 30);
        for (int i = 0; i < 3; i++) frame_d.push_back(0);
        run_frame(2, 2, 1'b0);
        frame_d.delete();
        for (int i = 0; i < 4; i++) frame_d.push_back(-(longint'(1) << 30));
        run_frame(2, 2, 1'b0);
        drain();

        // Backpressure on the output
        bp = 1;
        frame_d.delete();
        for (int i = 0; i < 16; i++) frame_d.push_back(longint'(i));
        run_frame(4, 4, 1'b0);
        drain();
        bp = 0;

        // Abort a frame with reset while a result is pending
        force_stall = 1;
        @(posedge clk);
        #1;
        cfg_rows = 5'd4;
        cfg_cols = 6'd4;
        cfg_relu = 1'b0;
        for (int i = 0; i < 6; i++) send(longint'(i), 1'b0);
        check("abort_pending", 64'(out_tvalid), 64'(1'b1));
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        force_stall = 0;
        check("abort_valid", 64'(out_tvalid), 64'(1'b0));
        check("abort_data", 64'(out_tdata), 64'(0));
        check("abort_state", 64'(dbg_state), 64'(IDLE));
        frame_d.delete();
        frame_d.push_back(1);
        frame_d.push_back(9);
        frame_d.push_back(3);
        frame_d.push_back(4);
        run_frame(2, 2, 1'b0);
        drain();

        repeat (3) @(posedge clk);
        #1;
        check("done_count", 64'(done_cnt), 64'(9));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
